// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags.
// Commits from the ROB write values in program order. Renames from the decoder
// mark a register as waiting on a ROB entry. Operand queries are combinational
// and forward a same-cycle commit that retires the pending producer.
module reg_file #(
    parameter int unsigned REG_ID_BIT    = 5,
    parameter int unsigned ROB_WIDTH_BIT = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     commit_en,
    input  logic [REG_ID_BIT-1:0]    commit_reg,
    input  logic [ROB_WIDTH_BIT-1:0] commit_rob_id,
    input  logic [31:0]              commit_value,
    input  logic                     rename_en,
    input  logic [REG_ID_BIT-1:0]    rename_reg,
    input  logic [ROB_WIDTH_BIT-1:0] rename_rob_id,
    input  logic                     clear_all,
    input  logic [REG_ID_BIT-1:0]    rs1_id,
    input  logic [REG_ID_BIT-1:0]    rs2_id,
    output logic [31:0]              rs1_value,
    output logic                     rs1_busy,
    output logic [ROB_WIDTH_BIT-1:0] rs1_reorder,
    output logic [31:0]              rs2_value,
    output logic                     rs2_busy,
    output logic [ROB_WIDTH_BIT-1:0] rs2_reorder
);

    localparam int unsigned NUM_REGS = 1 << REG_ID_BIT;
    localparam int unsigned DATA_W   = 32;

    logic [DATA_W-1:0]        val_q [NUM_REGS];
    logic [DATA_W-1:0]        val_d [NUM_REGS];
    logic [ROB_WIDTH_BIT-1:0] tag_q [NUM_REGS];
    logic [ROB_WIDTH_BIT-1:0] tag_d [NUM_REGS];
    logic [NUM_REGS-1:0]      busy_q;
    logic [NUM_REGS-1:0]      busy_d;

    logic commit_hit;
    logic rename_hit;

    // A commit only retires the pending producer if the tag still names it.
    assign commit_hit = commit_en && (commit_reg != '0) && busy_q[commit_reg]
                        && (tag_q[commit_reg] == commit_rob_id);
    assign rename_hit = rename_en && (rename_reg != '0);

    // Next-state: commit writes value, then flush or rename overrides busy/tag.
    always_comb begin
        val_d  = val_q;
        tag_d  = tag_q;
        busy_d = busy_q;
        if (rdy_in) begin
            if (commit_en && (commit_reg != '0)) begin
                val_d[commit_reg] = commit_value;
                if (commit_hit) begin
                    busy_d[commit_reg] = 1'b0;
                end
            end
            if (clear_all) begin
                busy_d = '0;
            end else if (rename_hit) begin
                busy_d[rename_reg] = 1'b1;
                tag_d[rename_reg]  = rename_rob_id;
            end
        end
    end

    // State registers with synchronous reset; x0 is never written.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_q <= '0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                val_q[i] <= val_d[i];
                tag_q[i] <= tag_d[i];
            end
        end
    end

    // Operand 1 lookup with same-cycle commit forwarding.
    always_comb begin
        rs1_value   = '0;
        rs1_busy    = 1'b0;
        rs1_reorder = '0;
        if (rs1_id != '0) begin
            rs1_reorder = tag_q[rs1_id];
            if (commit_hit && (commit_reg == rs1_id)) begin
                rs1_value = commit_value;
                rs1_busy  = 1'b0;
            end else begin
                rs1_value = val_q[rs1_id];
                rs1_busy  = busy_q[rs1_id];
            end
        end
    end

    // Operand 2 lookup with same-cycle commit forwarding.
    always_comb begin
        rs2_value   = '0;
        rs2_busy    = 1'b0;
        rs2_reorder = '0;
        if (rs2_id != '0) begin
            rs2_reorder = tag_q[rs2_id];
            if (commit_hit && (commit_reg == rs2_id)) begin
                rs2_value = commit_value;
                rs2_busy  = 1'b0;
            end else begin
                rs2_value = val_q[rs2_id];
                rs2_busy  = busy_q[rs2_id];
            end
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: a driver computes expected query results from
// a register-array model and queues them; a monitor pops and compares.
module tb_reg_file;

    localparam int unsigned REG_ID_BIT    = 5;
    localparam int unsigned ROB_WIDTH_BIT = 4;

    logic                     clk_in = 1'b0;
    logic                     rst_in;
    logic                     rdy_in;
    logic                     commit_en;
    logic [REG_ID_BIT-1:0]    commit_reg;
    logic [ROB_WIDTH_BIT-1:0] commit_rob_id;
    logic [31:0]              commit_value;
    logic                     rename_en;
    logic [REG_ID_BIT-1:0]    rename_reg;
    logic [ROB_WIDTH_BIT-1:0] rename_rob_id;
    logic                     clear_all;
    logic [REG_ID_BIT-1:0]    rs1_id;
    logic [REG_ID_BIT-1:0]    rs2_id;
    logic [31:0]              rs1_value;
    logic                     rs1_busy;
    logic [ROB_WIDTH_BIT-1:0] rs1_reorder;
    logic [31:0]              rs2_value;
    logic                     rs2_busy;
    logic [ROB_WIDTH_BIT-1:0] rs2_reorder;

    reg_file #(.REG_ID_BIT(REG_ID_BIT), .ROB_WIDTH_BIT(ROB_WIDTH_BIT)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .commit_en(commit_en), .commit_reg(commit_reg),
        .commit_rob_id(commit_rob_id), .commit_value(commit_value),
        .rename_en(rename_en), .rename_reg(rename_reg),
        .rename_rob_id(rename_rob_id), .clear_all(clear_all),
        .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_value(rs1_value), .rs1_busy(rs1_busy), .rs1_reorder(rs1_reorder),
        .rs2_value(rs2_value), .rs2_busy(rs2_busy), .rs2_reorder(rs2_reorder)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int          step_no;
        logic [4:0]  id1, id2;
        logic [31:0] v1, v2;
        logic        b1, b2;
        logic [3:0]  t1, t2;
    } exp_t;

    exp_t sb[$];

    // Reference model: plain arrays of architectural value, pending flag, producer tag.
    logic [31:0] m_val [32];
    logic        m_busy[32];
    logic [3:0]  m_tag [32];
    bit          model_valid = 0;

    int assertions = 0;
    int failures   = 0;
    int step_cnt   = 0;

    // Expected operand lookup, from the model state before the clock edge.
    task automatic lookup(input logic [4:0] id, input logic ce, input logic [4:0] cr,
                          input logic [3:0] crob, input logic [31:0] cv,
                          output logic [31:0] v, output logic b, output logic [3:0] t);
        if (id == 0) begin
            v = 0; b = 0; t = 0;
        end else if (ce && cr == id && m_busy[id] && m_tag[id] == crob) begin
            v = cv; b = 0; t = m_tag[id];
        end else begin
            v = m_val[id]; b = m_busy[id]; t = m_tag[id];
        end
    endtask

    // Drive one cycle of inputs, queue the expected query results, advance the model.
    task automatic step(input logic rst, input logic rdy,
                        input logic ce, input logic [4:0] cr, input logic [3:0] crob,
                        input logic [31:0] cv,
                        input logic re, input logic [4:0] rr, input logic [3:0] rrob,
                        input logic clr, input logic [4:0] r1, input logic [4:0] r2);
        exp_t e;
        @(negedge clk_in);
        rst_in = rst; rdy_in = rdy; commit_en = ce; commit_reg = cr;
        commit_rob_id = crob; commit_value = cv; rename_en = re; rename_reg = rr;
        rename_rob_id = rrob; clear_all = clr; rs1_id = r1; rs2_id = r2;
        step_cnt++;
        if (model_valid) begin
            e.step_no = step_cnt; e.id1 = r1; e.id2 = r2;
            lookup(r1, ce, cr, crob, cv, e.v1, e.b1, e.t1);
            lookup(r2, ce, cr, crob, cv, e.v2, e.b2, e.t2);
            sb.push_back(e);
        end
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_val[i] = 0; m_busy[i] = 0; m_tag[i] = 0;
            end
            model_valid = 1;
        end else if (rdy) begin
            if (ce && cr != 0) begin
                if (m_busy[cr] && m_tag[cr] == crob) m_busy[cr] = 0;
                m_val[cr] = cv;
            end
            if (clr) begin
                for (int i = 0; i < 32; i++) m_busy[i] = 0;
            end else if (re && rr != 0) begin
                m_busy[rr] = 1; m_tag[rr] = rrob;
            end
        end
    endtask

    task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, r1, r2);
    endtask

    // Monitor: query outputs are combinational, sampled mid-low-phase each cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_in);
            #2;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                assertions++;
                if ({rs1_value, rs1_busy, rs1_reorder} !== {e.v1, e.b1, e.t1}) begin
                    failures++;
                    $display("FAIL rs1 step %0d id %0d: got val=%h busy=%b tag=%h, exp val=%h busy=%b tag=%h",
                             e.step_no, e.id1, rs1_value, rs1_busy, rs1_reorder, e.v1, e.b1, e.t1);
                end
                assertions++;
                if ({rs2_value, rs2_busy, rs2_reorder} !== {e.v2, e.b2, e.t2}) begin
                    failures++;
                    $display("FAIL rs2 step %0d id %0d: got val=%h busy=%b tag=%h, exp val=%h busy=%b tag=%h",
                             e.step_no, e.id2, rs2_value, rs2_busy, rs2_reorder, e.v2, e.b2, e.t2);
                end
            end
        end
    end

    initial begin
        logic       ce, re, clr, rdy;
        logic [4:0] cr, rr, r1, r2;
        logic [3:0] crob;
        int         wait_cyc;

        // Reset, then query x5 and x0.
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
        step(1, 0, 1, 5, 0, 32'hDEAD, 1, 5, 3, 0, 5, 0);
        idle(5, 0);

        // Rename x3 -> tag 2, commit x3 with forwarding, then stored value.
        step(0, 1, 0, 0, 0, 0, 1, 3, 2, 0, 3, 0);
        step(0, 1, 1, 3, 2, 32'h1234, 0, 0, 0, 0, 3, 3);
        idle(3, 0);

        // Two renames of x4; commit of the older producer leaves it busy on tag 5.
        step(0, 1, 0, 0, 0, 0, 1, 4, 1, 0, 4, 0);
        step(0, 1, 0, 0, 0, 0, 1, 4, 5, 0, 4, 0);
        step(0, 1, 1, 4, 1, 32'h7, 0, 0, 0, 0, 4, 4);
        idle(4, 4);

        // Same-cycle rename and matching commit of x6.
        step(0, 1, 0, 0, 0, 0, 1, 6, 2, 0, 6, 0);
        step(0, 1, 1, 6, 2, 32'h9, 1, 6, 3, 0, 6, 0);
        idle(6, 6);

        // Rename x1, x2, x7, then flush with a dropped rename of x8.
        step(0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 1, 2, 1, 0, 1, 0);
        step(0, 1, 0, 0, 0, 0, 1, 7, 2, 0, 1, 2);
        step(0, 1, 0, 0, 0, 0, 1, 8, 3, 1, 7, 8);
        idle(1, 8);
        idle(2, 7);

        // x0 ignores commits/renames; rdy_in low freezes a commit to x9.
        step(0, 1, 1, 0, 0, 32'hFFFF, 1, 0, 5, 0, 0, 0);
        idle(0, 0);
        step(0, 0, 1, 9, 0, 32'hAB, 1, 9, 4, 0, 9, 0);
        step(0, 0, 1, 9, 0, 32'hAB, 0, 0, 0, 1, 9, 9);
        idle(9, 0);
        step(0, 1, 1, 9, 0, 32'hAB, 0, 0, 0, 0, 9, 0);
        idle(9, 0);

        // Randomized traffic concentrated on a few registers to force collisions.
        for (int n = 0; n < 600; n++) begin
            rdy  = ($urandom_range(0, 9) != 0);
            ce   = $urandom_range(0, 1);
            cr   = 5'($urandom_range(0, 7));
            crob = ($urandom_range(0, 1) != 0) ? m_tag[cr] : 4'($urandom);
            re   = $urandom_range(0, 1);
            rr   = 5'($urandom_range(0, 7));
            clr  = ($urandom_range(0, 19) == 0);
            r1   = ($urandom_range(0, 2) == 0) ? cr : 5'($urandom_range(0, 7));
            r2   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            step(($urandom_range(0, 199) == 0), rdy, ce, cr, crob, $urandom,
                 re, rr, 4'($urandom), clr, r1, r2);
        end

        // Drain the scoreboard within a bounded number of cycles.
        wait_cyc = 0;
        while (sb.size() > 0 && wait_cyc < 20) begin
            @(negedge clk_in);
            wait_cyc++;
        end
        @(negedge clk_in);
        #4;
        if (sb.size() > 0) begin
            assertions++;
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Architectural register file with per-register rename tags. It is the receiving end of the ROB commit interface (write_en / reg_id / rob_id / value_out).
- Holds 32 integer registers. Each register records which ROB entry will produce its next value.
- The decoder queries it for operands and receives either a committed value or a pending ROB tag. The decoder resolves a pending tag through the ROB's reoder_1/reoder_2 lookup.
- All pending tags are discarded on a ROB clear_all, i.e. a misprediction flush.

Parameters:
- REG_ID_BIT, 5, register index width (32 registers).
- ROB_WIDTH_BIT, 4, ROB tag width.

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  synchronous reset, active-high.
- rdy_in  input  1  pause when low; all state holds.
- commit_en  input  1  ROB commit strobe (driven by ROB write_en).
- commit_reg  input  REG_ID_BIT  destination register of the committing instruction (ROB reg_id).
- commit_rob_id  input  ROB_WIDTH_BIT  ROB entry being committed (ROB rob_id).
- commit_value  input  32  committed value (ROB value_out).
- rename_en  input  1  decoder issues an instruction that writes rd.
- rename_reg  input  REG_ID_BIT  rd of the issuing instruction.
- rename_rob_id  input  ROB_WIDTH_BIT  ROB entry allocated to the instruction (ROB rob_free_id).
- clear_all  input  1  flush every pending tag.
- rs1_id  input  REG_ID_BIT  operand 1 register index.
- rs2_id  input  REG_ID_BIT  operand 2 register index.
- rs1_value  output  32  operand 1 value; valid only when rs1_busy is 0.
- rs1_busy  output  1  operand 1 is awaiting a ROB result.
- rs1_reorder  output  ROB_WIDTH_BIT  tag of the producer of operand 1; valid when rs1_busy is 1.
- rs2_value, rs2_busy, rs2_reorder  output  32/1/ROB_WIDTH_BIT  same as rs1_* for operand 2.

Behaviour:
- State:
  - val[0..31], 32 bits each.
  - busy[0..31], 1 bit each.
  - tag[0..31], ROB_WIDTH_BIT each.
- Reset: on a clk_in edge with rst_in high, every val, busy and tag is set to 0. rst_in takes priority over rdy_in. After reset every query returns value 0, busy 0, reorder 0.
- rdy_in low with rst_in low: no state changes. Query outputs stay combinational.
- Register x0:
  - Always reads value 0, busy 0, reorder 0.
  - Commits and renames targeting x0 are ignored.
- Commit (rising edge, rdy_in high, commit_en high, commit_reg != 0):
  - val[commit_reg] <= commit_value, unconditionally, because commits arrive in program order.
  - busy[commit_reg] <= 0 only if busy is set and tag[commit_reg] == commit_rob_id.
  - If tag[commit_reg] differs, a younger writer is still pending, so busy and tag remain unchanged.
- Rename (rising edge, rdy_in high, rename_en high, rename_reg != 0, clear_all low):
  - busy[rename_reg] <= 1.
  - tag[rename_reg] <= rename_rob_id.
- Rename and commit on the same register in the same cycle: the rename wins for busy/tag (busy = 1, tag = new). The commit still writes val.
- clear_all high (rdy_in high):
  - All busy <= 0 in that cycle.
  - Any rename in that cycle is dropped.
  - A commit in the same cycle still updates val.
  - Tags need not be cleared.
- Query path: combinational, zero latency, with same-cycle commit forwarding. For rsX_id != 0:
  - If commit_en is high, commit_reg == rsX_id, busy is set and tag == commit_rob_id, the outputs are value = commit_value, busy = 0, reorder = tag.
  - Otherwise the outputs are value = val[rsX_id], busy = busy[rsX_id], reorder = tag[rsX_id].
  - Forwarding is not gated by rdy_in.
- The rename in the current cycle does not affect the current-cycle query outputs. Self-dependency (rd == rs of the same instruction) therefore sees the old producer.
- Both query ports are independent; rs1_id == rs2_id returns identical results on both.
- No internal FSM beyond the per-register busy/tag state. Every write happens at most once per register per cycle, with the priority order rst_in > rdy_in > clear_all/rename/commit as defined above.

Test Plan:
- Reset, then query rs1 = 5, rs2 = 0 -> both ports return value 0, busy 0, reorder 0.
- Rename x3 to tag 2, then next cycle commit x3, rob 2, value 0x1234, while querying rs1 = 3 -> same cycle: rs1_value = 0x1234, rs1_busy = 0. Next cycle: val[3] = 0x1234, busy 0.
- Rename x4 to tag 1, rename x4 to tag 5, then commit x4, rob 1, value 7 -> val[4] = 7, busy[4] = 1, tag[4] = 5, and the query returns busy 1 with reorder 5.
- Same-cycle rename of x6 to tag 3 together with a commit of x6 whose tag matches, value 9 -> val[6] = 9, busy[6] = 1, tag[6] = 3.
- Rename x1, x2, x7 (tags 0, 1, 2), then clear_all together with rename x8 to tag 3 -> all busy 0, x8 not busy, vals unchanged.
- Commit x0, value 0xFFFF, plus rename x0; also hold rdy_in low during a commit to x9 -> x0 reads 0 and not busy; x9 unchanged until rdy_in returns high.
